gate_unit_arbiter: RTL and testbench
====================================

Name: gate_unit_arbiter

Overview:
Round-robin arbiter and sequencer that shares one external combinational gate unit (e.g. a W-bit inverter bank) among N requesters. It accepts one request at a time, drives the operand onto the shared unit, and waits a fixed LAT cycles for the unit to settle. It then captures the result and returns it tagged with the requester id. It sits between the lab's requester blocks and a single gate-unit instance.

Parameters:
N, 4, number of requesters (2..8, any value, not only powers of 2)
W, 8, operand/result width in bits
LAT, 1, settle time of the shared gate unit in clock cycles (1..15)

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, synchronous and active-high
req  input  N  req[i]=1: requester i has an operation pending; held until it sees gnt[i]
req_data  input  N*W  operand of requester i in slice [i*W +: W]
gnt  output  N  one-hot, 1-cycle pulse: request of requester i accepted
gu_in  output  W  operand driven to shared gate unit
gu_out  input  W  result from shared gate unit, valid LAT cycles after gu_in changes
rsp_valid  output  1  1-cycle pulse: rsp_data/rsp_id valid
rsp_id  output  clog2(N) (min 1)  index of requester that owns rsp_data
rsp_data  output  W  captured gate-unit result
busy  output  1  1 when state != IDLE

Behaviour:
- All outputs are registered.
- Reset: state=IDLE, ptr=0, cnt=0, gnt=0, gu_in=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If req==0: stay in IDLE.
  - Else grant the first i with req[i]=1, searching ptr, ptr+1, ... mod N.
  - At the edge: gnt<=onehot(i), gu_in<=req_data[i], id<=i, cnt<=LAT, ptr<=(i+1) mod N, state<=RUN.
- RUN:
  - gnt is high only in the first RUN cycle, then 0.
  - cnt decrements at each edge.
  - At the edge where cnt==1: rsp_data<=gu_out, rsp_id<=id, rsp_valid<=1, state<=DONE.
  - RUN lasts exactly LAT cycles.
- DONE: rsp_valid high for this single cycle; next edge: rsp_valid<=0, state<=IDLE.
- Timing: request sampled at edge k -> gnt high in cycle k+1 -> rsp_valid high in cycle k+1+LAT. One operation per LAT+2 cycles.
- Arbitration occurs only in IDLE. req changes during RUN/DONE are ignored until IDLE.
- Hold rules:
  - gu_in holds its operand from grant until the next grant.
  - rsp_data/rsp_id hold until the next rsp_valid.
- A requester dropping req before being granted is legal; it receives no gnt and no response.
- A requester that keeps req high after gnt is treated as a new request at the next IDLE.
- Wrap: ptr goes N-1 -> 0. Correct for non-power-of-2 N; ptr never holds a value >= N.
- Reset mid-operation (RUN or DONE): the operation is aborted. No rsp_valid is produced; all outputs and ptr return to reset values on the next cycle.
- rst has priority over every other event in the same cycle.

Optional Feature:
Macro GATE_ARB_GRANT_COUNT_EN.
- Defined:
  - Adds output port grant_count [15:0], cleared by rst.
  - Increments by 1 on every grant (the edge leaving IDLE); wraps 16'hFFFF -> 0.
  - An aborted operation's grant remains counted.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Bench models gu_out = ~gu_in with LAT-cycle delay. N=4, W=8, LAT=1. Release rst, req=4'b0001, data0=8'h0F -> gnt=4'b0001 one cycle after req is sampled; next cycle rsp_valid=1, rsp_id=0, rsp_data=8'hF0; busy high for 2 cycles.
- req=4'b1111 held, each requester drops its req the cycle after its gnt -> grant order 0,1,2,3; gnt pulses 3 cycles apart; rsp_data = complement of each operand.
- After a grant to requester 3, req=4'b1001 -> requester 0 granted next (wrap); then requester 3 on the following grant.
- rst asserted for 1 cycle during RUN (LAT=3, second RUN cycle) -> no rsp_valid ever for that op; all outputs 0; next req=4'b0110 grants requester 1.
- LAT=3, req=4'b0100, data2=8'hA5 -> gnt in cycle k+1, rsp_valid in cycle k+4, rsp_id=2, rsp_data=8'h5A; req toggled on requester 0 during RUN is ignored until IDLE.
- With GATE_ARB_GRANT_COUNT_EN: 5 completed grants -> grant_count=5; rst -> 0. Without the macro: the same bench compiles with the port absent and all other checks pass.

Source files
------------

// File: rtl/gate_unit_arbiter.sv
// gate_unit_arbiter
//   Round-robin arbiter and sequencer that shares one external combinational gate unit among
//   N requesters. One request is accepted at a time. Its operand is driven onto the gate unit,
//   the unit is given LAT cycles to settle, and the result is returned tagged with the id of
//   the requester that owns it.
//
//   Parameters: N (requesters, 2..8), W (operand width), LAT (gate-unit settle cycles, 1..15).
//
//   Ports:
//     clk          rising-edge clock
//     rst          synchronous active-high reset
//     req[N]       pending request per requester, held until its gnt
//     req_data     operand of requester i in slice [i*W +: W]
//     gnt[N]       one-hot 1-cycle pulse, request accepted
//     gu_in[W]     operand driven to the shared gate unit
//     gu_out[W]    gate-unit result, valid LAT cycles after gu_in changes
//     rsp_valid    1-cycle pulse, rsp_id/rsp_data valid
//     rsp_id       requester that owns rsp_data
//     rsp_data     captured gate-unit result
//     busy         high whenever an operation is in flight (state != IDLE)
//     grant_count  16-bit wrapping grant counter, present only when GATE_ARB_GRANT_COUNT_EN
//                  is defined
//
//   Optional feature macro: GATE_ARB_GRANT_COUNT_EN.
module gate_unit_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned W   = 8,
  parameter int unsigned LAT = 1,
  localparam int unsigned IdW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   gnt,
  output logic [W-1:0]   gu_in,
  input  logic [W-1:0]   gu_out,
  output logic           rsp_valid,
  output logic [IdW-1:0] rsp_id,
  output logic [W-1:0]   rsp_data,
  output logic           busy
`ifdef GATE_ARB_GRANT_COUNT_EN
  ,
  output logic [15:0]    grant_count
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         state;
  logic [IdW-1:0] ptr;
  logic [IdW-1:0] id;
  logic [3:0]     cnt;

  logic           found;
  logic [IdW-1:0] pick;
  logic [IdW-1:0] pick_next;
  logic [N-1:0]   pick_oh;
  logic [W-1:0]   pick_data;
  int unsigned    cand;

  logic [W-1:0]   data_arr [N];

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*W +: W];
  end

  // Search ptr, ptr+1, ... wrapping at N (not at a power of two), first pending request wins.
  always_comb begin
    found   = 1'b0;
    pick    = '0;
    pick_oh = '0;
    cand    = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!found && req[cand[IdW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IdW-1:0];
      end
    end
    pick_oh[pick] = 1'b1;
    pick_data     = data_arr[pick];
    pick_next     = (pick == IdW'(N - 1)) ? '0 : pick + IdW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      ptr         <= '0;
      id          <= '0;
      cnt         <= '0;
      gnt         <= '0;
      gu_in       <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_data    <= '0;
      busy        <= 1'b0;
`ifdef GATE_ARB_GRANT_COUNT_EN
      grant_count <= '0;
`endif
    end else begin
      // Both pulses last a single cycle unless re-asserted below.
      gnt       <= '0;
      rsp_valid <= 1'b0;
      unique case (state)
        StIdle: begin
          if (found) begin
            gnt   <= pick_oh;
            gu_in <= pick_data;
            id    <= pick;
            cnt   <= 4'(LAT);
            ptr   <= pick_next;
            busy  <= 1'b1;
            state <= StRun;
`ifdef GATE_ARB_GRANT_COUNT_EN
            grant_count <= grant_count + 16'd1;
`endif
          end
        end
        StRun: begin
          cnt <= cnt - 4'd1;
          // cnt==1 marks the last settle cycle: gu_out now reflects gu_in.
          if (cnt == 4'd1) begin
            rsp_data  <= gu_out;
            rsp_id    <= id;
            rsp_valid <= 1'b1;
            state     <= StDone;
          end
        end
        StDone: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Bench for gate_unit_arbiter. Two instances: A (N=4, W=8, LAT=1) and B (N=5, W=8, LAT=3).
// The shared gate unit is modelled as an inverter whose output only reflects gu_in after LAT
// cycles. Build with +define+GATE_ARB_GRANT_COUNT_EN to also exercise grant_count.
module tb_gate_unit_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A
  logic        rst_a;
  logic [3:0]  req_a;
  logic [31:0] data_a;
  logic [3:0]  gnt_a;
  logic [7:0]  gu_in_a, gu_out_a, rspd_a;
  logic        rspv_a, busy_a;
  logic [1:0]  rspid_a;
  // Instance B
  logic        rst_b;
  logic [4:0]  req_b;
  logic [39:0] data_b;
  logic [4:0]  gnt_b;
  logic [7:0]  gu_in_b, gu_out_b, rspd_b;
  logic        rspv_b, busy_b;
  logic [2:0]  rspid_b;
`ifdef GATE_ARB_GRANT_COUNT_EN
  logic [15:0] gc_a, gc_b;
`endif

  // Gate units: A settles within one cycle, B is a two-stage delay so it settles in three.
  assign gu_out_a = ~gu_in_a;
  logic [7:0] gb_p1, gb_p2;
  always @(posedge clk) begin
    gb_p1 <= ~gu_in_b;
    gb_p2 <= gb_p1;
  end
  assign gu_out_b = gb_p2;

  gate_unit_arbiter #(.N(4), .W(8), .LAT(1)) u_dut_a (
    .clk(clk), .rst(rst_a), .req(req_a), .req_data(data_a), .gnt(gnt_a), .gu_in(gu_in_a),
    .gu_out(gu_out_a), .rsp_valid(rspv_a), .rsp_id(rspid_a), .rsp_data(rspd_a), .busy(busy_a)
`ifdef GATE_ARB_GRANT_COUNT_EN
    , .grant_count(gc_a)
`endif
  );

  gate_unit_arbiter #(.N(5), .W(8), .LAT(3)) u_dut_b (
    .clk(clk), .rst(rst_b), .req(req_b), .req_data(data_b), .gnt(gnt_b), .gu_in(gu_in_b),
    .gu_out(gu_out_b), .rsp_valid(rspv_b), .rsp_id(rspid_b), .rsp_data(rspd_b), .busy(busy_b)
`ifdef GATE_ARB_GRANT_COUNT_EN
    , .grant_count(gc_b)
`endif
  );

  // Bounded waits; a timeout returns g=0 / ok=0 so the caller's comparison fails.
  task automatic wait_gnt_a(output logic [3:0] g, output int at);
    g = '0; at = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt_a !== 4'b0) begin g = gnt_a; at = cyc; return; end
    end
  endtask

  task automatic wait_gnt_b(output logic [4:0] g, output int at);
    g = '0; at = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt_b !== 5'b0) begin g = gnt_b; at = cyc; return; end
    end
  endtask

  task automatic wait_rsp_b(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rspv_b === 1'b1) begin ok = 1'b1; return; end
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; req_a = '0; req_b = '0; data_a = '0; data_b = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({gnt_a, gu_in_a, rspv_a, rspid_a, rspd_a, busy_a} !== 24'b0) begin
      n_fail++;
      $display("FAIL reset_a: got gnt=%b gu_in=%h v=%b id=%0d d=%h busy=%b want all 0",
               gnt_a, gu_in_a, rspv_a, rspid_a, rspd_a, busy_a);
    end
    n_tests++;
    if ({gnt_b, gu_in_b, rspv_b, rspid_b, rspd_b, busy_b} !== 26'b0) begin
      n_fail++;
      $display("FAIL reset_b: got gnt=%b gu_in=%h v=%b id=%0d d=%h busy=%b want all 0",
               gnt_b, gu_in_b, rspv_b, rspid_b, rspd_b, busy_b);
    end
`ifdef GATE_ARB_GRANT_COUNT_EN
    n_tests++;
    if (gc_a !== 16'd0) begin n_fail++; $display("FAIL reset_gc: got %0d want 0", gc_a); end
`endif
    rst_a = 1'b0; rst_b = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [3:0] g;
    int at, prev_at;
    prev_at = 0;
    data_a = 32'h4433_2211;
    req_a  = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_gnt_a(g, at);
      n_tests++;
      if (g !== 4'(1 << i)) begin
        n_fail++; $display("FAIL rr_order[%0d]: got gnt=%b want %b", i, g, 4'(1 << i));
      end
      if (i > 0) begin
        n_tests++;
        if (at - prev_at != 3) begin
          n_fail++; $display("FAIL rr_spacing[%0d]: got %0d cycles want 3", i, at - prev_at);
        end
      end
      prev_at = at;
      req_a[i] = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({rspv_a, rspid_a, rspd_a} !== {1'b1, 2'(i), ~data_a[i*8 +: 8]}) begin
        n_fail++;
        $display("FAIL rr_rsp[%0d]: got v=%b id=%0d d=%h want v=1 id=%0d d=%h",
                 i, rspv_a, rspid_a, rspd_a, i, ~data_a[i*8 +: 8]);
      end
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    data_a = 32'h0000_000F;
    req_a  = 4'b0001;
    @(negedge clk);
    n_tests++;
    if ({gnt_a, busy_a, rspv_a, gu_in_a} !== {4'b0001, 1'b1, 1'b0, 8'h0F}) begin
      n_fail++;
      $display("FAIL single_gnt: got gnt=%b busy=%b v=%b gu_in=%h want 0001 1 0 0f",
               gnt_a, busy_a, rspv_a, gu_in_a);
    end
    req_a = 4'b0000;
    @(negedge clk);
    n_tests++;
    if ({gnt_a, busy_a, rspv_a, rspid_a, rspd_a} !== {4'b0000, 1'b1, 1'b1, 2'd0, 8'hF0}) begin
      n_fail++;
      $display("FAIL single_rsp: got gnt=%b busy=%b v=%b id=%0d d=%h want 0000 1 1 0 f0",
               gnt_a, busy_a, rspv_a, rspid_a, rspd_a);
    end
    @(negedge clk);
    n_tests++;
    if ({busy_a, rspv_a, rspd_a, gu_in_a} !== {1'b0, 1'b0, 8'hF0, 8'h0F}) begin
      n_fail++;
      $display("FAIL single_idle_hold: got busy=%b v=%b d=%h gu_in=%h want 0 0 f0 0f",
               busy_a, rspv_a, rspd_a, gu_in_a);
    end
  endtask

`ifdef GATE_ARB_GRANT_COUNT_EN
  task automatic test_grant_count();
    n_tests++;
    if (gc_a !== 16'd5) begin n_fail++; $display("FAIL gc_five: got %0d want 5", gc_a); end
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    n_tests++;
    if (gc_a !== 16'd0) begin n_fail++; $display("FAIL gc_reset: got %0d want 0", gc_a); end
  endtask
`endif

  task automatic test_wrap();
    logic [3:0] g;
    int at;
    data_a = 32'hC3B2_A190;
    req_a  = 4'b1000;
    wait_gnt_a(g, at);
    n_tests++;
    if (g !== 4'b1000) begin n_fail++; $display("FAIL wrap_first: got %b want 1000", g); end
    req_a = 4'b1001;
    wait_gnt_a(g, at);
    n_tests++;
    if (g !== 4'b0001) begin n_fail++; $display("FAIL wrap_to0: got %b want 0001", g); end
    req_a = 4'b1000;
    wait_gnt_a(g, at);
    n_tests++;
    if (g !== 4'b1000) begin n_fail++; $display("FAIL wrap_then3: got %b want 1000", g); end
    req_a = 4'b0000;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_latency_b();
    logic [4:0] g;
    int at, t0;
    bit ok;
    data_b = 40'h00_00A5_003C;
    req_b  = 5'b00100;
    wait_gnt_b(g, t0);
    n_tests++;
    if (g !== 5'b00100) begin n_fail++; $display("FAIL lat3_gnt: got %b want 00100", g); end
    req_b = 5'b00001;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      n_tests++;
      if ({gnt_b, rspv_b, busy_b} !== {5'b0, j == 3, j <= 3}) begin
        n_fail++;
        $display("FAIL lat3_cycle[%0d]: got gnt=%b v=%b busy=%b want 00000 %0d %0d",
                 j, gnt_b, rspv_b, busy_b, j == 3, j <= 3);
      end
      if (j == 3) begin
        n_tests++;
        if ({rspid_b, rspd_b} !== {3'd2, 8'h5A}) begin
          n_fail++; $display("FAIL lat3_rsp: got id=%0d d=%h want 2 5a", rspid_b, rspd_b);
        end
      end
      // Requester 0 toggles while the op is in flight; only its level at IDLE counts.
      if (j < 3) req_b[0] = ~req_b[0];
    end
    req_b[0] = 1'b1;
    wait_gnt_b(g, at);
    n_tests++;
    if (g !== 5'b00001 || at - t0 != 5) begin
      n_fail++; $display("FAIL lat3_next: got gnt=%b after %0d want 00001 after 5", g, at - t0);
    end
    req_b = '0;
    wait_rsp_b(ok);
    n_tests++;
    if (!ok || {rspid_b, rspd_b} !== {3'd0, 8'hC3}) begin
      n_fail++; $display("FAIL lat3_rsp0: got ok=%b id=%0d d=%h want 1 0 c3", ok, rspid_b, rspd_b);
    end
  endtask

  task automatic test_abort_b();
    logic [4:0] g;
    int at;
    bit seen;
    data_b = 40'h00_0000_7700;
    req_b  = 5'b00010;
    wait_gnt_b(g, at);
    n_tests++;
    if (g !== 5'b00010) begin n_fail++; $display("FAIL abort_gnt: got %b want 00010", g); end
    req_b = '0;
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    n_tests++;
    if ({gnt_b, gu_in_b, rspv_b, rspid_b, rspd_b, busy_b} !== 26'b0) begin
      n_fail++;
      $display("FAIL abort_zero: got gnt=%b gu_in=%h v=%b id=%0d d=%h busy=%b want all 0",
               gnt_b, gu_in_b, rspv_b, rspid_b, rspd_b, busy_b);
    end
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rspv_b !== 1'b0) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin n_fail++; $display("FAIL abort_no_rsp: got rsp_valid=1 want none"); end
    req_b = 5'b00110;
    wait_gnt_b(g, at);
    n_tests++;
    if (g !== 5'b00010) begin n_fail++; $display("FAIL abort_regrant: got %b want 00010", g); end
    req_b = '0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_random_b();
    logic [4:0] g, mask;
    logic [7:0] op;
    int at, prev_at, ptr_m, w, c;
    bit ok;
    rst_b = 1'b1;
    @(negedge clk);
    rst_b  = 1'b0;
    ptr_m  = 0;
    prev_at = -1;
    mask   = 5'($urandom_range(1, 31));
    data_b = {8'($urandom), $urandom};
    req_b  = mask;
    for (int it = 0; it < 25; it++) begin
      wait_gnt_b(g, at);
      w = -1;
      for (int k = 0; k < 5; k++) begin
        c = (ptr_m + k) % 5;
        if (w < 0 && mask[c]) w = c;
      end
      op = data_b[w*8 +: 8];
      n_tests++;
      if (g !== 5'(1 << w) || gu_in_b !== op) begin
        n_fail++;
        $display("FAIL rand_gnt[%0d]: got gnt=%b gu_in=%h want %b %h", it, g, gu_in_b,
                 5'(1 << w), op);
      end
      if (prev_at >= 0) begin
        n_tests++;
        if (at - prev_at != 5) begin
          n_fail++; $display("FAIL rand_gap[%0d]: got %0d want 5", it, at - prev_at);
        end
      end
      prev_at = at;
      ptr_m   = (w + 1) % 5;
      mask    = 5'($urandom);
      data_b  = {8'($urandom), $urandom};
      req_b   = mask;
      wait_rsp_b(ok);
      n_tests++;
      if (!ok || rspid_b !== 3'(w) || rspd_b !== ~op || gu_in_b !== op) begin
        n_fail++;
        $display("FAIL rand_rsp[%0d]: got ok=%b id=%0d d=%h gu_in=%h want 1 %0d %h %h",
                 it, ok, rspid_b, rspd_b, gu_in_b, w, ~op, op);
      end
      if (mask == 5'b0) begin
        mask  = 5'(1 << $urandom_range(0, 4));
        req_b = mask;
      end
    end
    req_b = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
`ifdef GATE_ARB_GRANT_COUNT_EN
    test_grant_count();
`endif
    test_wrap();
    test_latency_b();
    test_abort_b();
    test_random_b();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
